// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding,
// reset address default and instruction word size.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/add4.sv
// Program-counter incrementer: advances by one instruction word, wrapping modulo 2^32.
module add4
  import mips_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);

  assign y = a + WORD_BYTES;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word reads, holds the fetched word for
// decode, and squashes in-flight or held fetches on a control-flow redirect.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus4_s;

  add4 u_add4 (
    .a (pc_q),
    .y (pc_plus4_s)
  );

  // Next-state and datapath updates; redirect outranks ack and id_ready.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = word_align(redirect_pc);
          state_d = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4_s;
          valid_d = 1'b1;
          pc_d    = pc_plus4_s;
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = word_align(redirect_pc);
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (id_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        // The stale read must still complete; a new redirect only retargets pc.
        if (redirect_valid) begin
          pc_d = word_align(redirect_pc);
        end else begin
          pc_d = pc_q;
        end
        if (imem_ack) begin
          state_d = FETCH;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      count_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc4      = pc4_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table-driven fetch/deliver vectors
// with a scoreboard queue, plus hand sequences for redirect and reset corners.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, imem_ack, redirect_valid, id_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc4, fetch_count;

  logic        w_rst_n, w_imem_ack, w_redirect_valid, w_id_ready;
  logic [31:0] w_imem_rdata, w_redirect_pc;
  logic        w_imem_req, w_if_valid;
  logic [31:0] w_imem_addr, w_if_instr, w_if_pc4, w_fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [31:0] addr;
    int unsigned ack_delay;
    int unsigned hold;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc4(if_pc4), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .id_ready(w_id_ready), .if_valid(w_if_valid),
    .if_instr(w_if_instr), .if_pc4(w_if_pc4), .fetch_count(w_fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ack the current fetch and compare the delivered word against the scoreboard.
  task automatic ack_and_check(input logic [31:0] addr);
    exp_t e;
    imem_ack   = 1'b1;
    imem_rdata = mem_word(addr);
    sb_q.push_back({mem_word(addr), addr + 32'd4});
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    chk("valid_after_ack", {31'd0, if_valid}, 32'd1);
    chk("req_in_hold", {31'd0, imem_req}, 32'd0);
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb_q.pop_front();
      chk("if_instr", if_instr, e.instr);
      chk("if_pc4", if_pc4, e.pc4);
    end
  endtask

  task automatic fetch_deliver(input logic [31:0] addr, input int unsigned delay,
                               input int unsigned hold, input logic [31:0] prev_cnt);
    for (int i = 0; i < int'(delay); i++) begin
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      chk("addr_wait", imem_addr, addr);
      step();
    end
    chk("req_at_ack", {31'd0, imem_req}, 32'd1);
    chk("addr_at_ack", imem_addr, addr);
    ack_and_check(addr);
    for (int i = 0; i < int'(hold); i++) begin
      step();
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_instr", if_instr, mem_word(addr));
      chk("hold_pc4", if_pc4, addr + 32'd4);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_count", fetch_count, prev_cnt);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk("valid_after_accept", {31'd0, if_valid}, 32'd0);
    chk("fetch_count", fetch_count, prev_cnt + 32'd1);
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, addr + 32'd4);
  endtask

  initial begin
    vecs[0] = '{addr: 32'h0000_0000, ack_delay: 1, hold: 0};
    vecs[1] = '{addr: 32'h0000_0004, ack_delay: 1, hold: 0};
    vecs[2] = '{addr: 32'h0000_0008, ack_delay: 1, hold: 0};
    vecs[3] = '{addr: 32'h0000_000C, ack_delay: 2, hold: 5};

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; id_ready = 1'b0;
    w_rst_n = 1'b0; w_imem_ack = 1'b0; w_imem_rdata = 32'h0; w_redirect_valid = 1'b0;
    w_redirect_pc = 32'h0; w_id_ready = 1'b0;
    step();
    step();

    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("w_rst_addr", w_imem_addr, 32'hFFFF_FFFC);

    rst_n = 1'b1;
    step();
    chk("leave_idle_req", {31'd0, imem_req}, 32'd1);
    chk("leave_idle_addr", imem_addr, 32'h0000_0000);

    for (int v = 0; v < 4; v++) begin
      fetch_deliver(vecs[v].addr, vecs[v].ack_delay, vecs[v].hold, 32'(v));
      if (v == 2) chk("count_after_three", fetch_count, 32'd3);
    end

    // Redirect while the read to 0x10 is pending; ack arrives two cycles later.
    step();
    chk("pending_addr", imem_addr, 32'h0000_0010);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    chk("drop_addr", imem_addr, 32'h0000_0100);
    step();
    chk("drop_wait_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    chk("dropped_valid", {31'd0, if_valid}, 32'd0);
    chk("after_drop_req", {31'd0, imem_req}, 32'd1);
    chk("after_drop_addr", imem_addr, 32'h0000_0100);
    fetch_deliver(32'h0000_0100, 0, 0, 32'd4);

    // Redirect in HOLD together with id_ready: squash without counting.
    ack_and_check(32'h0000_0104);
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0020;
    step();
    id_ready = 1'b0; redirect_valid = 1'b0;
    chk("hold_redir_valid", {31'd0, if_valid}, 32'd0);
    chk("hold_redir_count", fetch_count, 32'd5);
    chk("hold_redir_addr", imem_addr, 32'h0000_0020);

    // Redirect coincident with ack at 0x20.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0020;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    chk("coinc_valid", {31'd0, if_valid}, 32'd0);
    chk("coinc_req", {31'd0, imem_req}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h0000_0200);
    step();
    chk("coinc_valid_later", {31'd0, if_valid}, 32'd0);
    fetch_deliver(32'h0000_0200, 1, 0, 32'd5);

    // Second redirect while in DROP only retargets pc.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0303;
    step();
    chk("drop2_addr", imem_addr, 32'h0000_0300);
    redirect_pc = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    chk("drop2_req", {31'd0, imem_req}, 32'd0);
    chk("drop2_retarget", imem_addr, 32'h0000_0400);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0204;
    step();
    imem_ack = 1'b0;
    chk("drop2_exit_req", {31'd0, imem_req}, 32'd1);
    chk("drop2_exit_addr", imem_addr, 32'h0000_0400);
    chk("drop2_exit_valid", {31'd0, if_valid}, 32'd0);

    // Reset mid-fetch, with ack while low and on the cycle after release.
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'h0000_0000);
    chk("async_rst_count", fetch_count, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0400;
    step();
    chk("rst_ack_valid", {31'd0, if_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, if_valid}, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0000_0000);
    step();
    chk("late_ack_valid2", {31'd0, if_valid}, 32'd0);
    fetch_deliver(32'h0000_0000, 0, 0, 32'd0);

    // Wrapping reset address on the second instance.
    w_rst_n = 1'b1;
    step();
    chk("w_req", {31'd0, w_imem_req}, 32'd1);
    chk("w_addr", w_imem_addr, 32'hFFFF_FFFC);
    w_imem_ack = 1'b1; w_imem_rdata = 32'h1234_5678;
    step();
    w_imem_ack = 1'b0;
    chk("w_valid", {31'd0, w_if_valid}, 32'd1);
    chk("w_instr", w_if_instr, 32'h1234_5678);
    chk("w_pc4_wrap", w_if_pc4, 32'h0000_0000);
    w_id_ready = 1'b1;
    step();
    w_id_ready = 1'b0;
    chk("w_second_addr", w_imem_addr, 32'h0000_0000);
    chk("w_second_req", {31'd0, w_imem_req}, 32'd1);
    chk("w_count", w_fetch_count, 32'd1);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction memory read request.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_ack  input  1  read complete, imem_rdata valid this cycle.
REQ-008 SHALL have port imem_rdata  input  32  instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken, one-cycle pulse from ID/EX.
REQ-010 SHALL have port redirect_pc  input  32  new fetch address.
REQ-011 SHALL have port id_ready  input  1  decode accepts the held instruction this cycle.
REQ-012 SHALL have port if_valid  output  1  if_instr/if_pc4 hold a deliverable instruction.
REQ-013 SHALL have port if_instr  output  32  fetched instruction.
REQ-014 SHALL have port if_pc4  output  32  fetch address of if_instr plus 4.
REQ-015 SHALL have port fetch_count  output  32  count of instructions accepted by decode.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD, DROP in a registered state machine.
REQ-017 SHALL leave IDLE for FETCH on the first clock after rst_n deasserts.
REQ-018 SHALL assert imem_req only in FETCH, holding imem_addr = pc stable until imem_ack.
REQ-019 SHALL, in FETCH on imem_ack without redirect, register if_instr = imem_rdata, if_pc4 = pc+4, set if_valid next cycle, pc <= pc+4, go to HOLD.
REQ-020 SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-021 SHALL, in HOLD, keep if_valid/if_instr/if_pc4 stable while id_ready=0.
REQ-022 SHALL, in HOLD with id_ready=1, clear if_valid next cycle, increment fetch_count (wrapping at 2^32), go to FETCH.
REQ-023 SHALL give redirect_valid priority over every other event in every state except IDLE.
REQ-024 SHALL load pc <= {redirect_pc[31:2], 2'b00} on redirect (low two bits ignored).
REQ-025 SHALL, on redirect in FETCH without same-cycle ack, go to DROP (request outstanding).
REQ-026 SHALL, on redirect in FETCH with same-cycle ack, discard imem_rdata, stay in FETCH, drive the new address next cycle.
REQ-027 SHALL, on redirect in HOLD, clear if_valid next cycle, not increment fetch_count even if id_ready=1, go to FETCH.
REQ-028 SHALL, in DROP, keep imem_req=0, discard data on imem_ack, go to FETCH; a further redirect in DROP only updates pc.
REQ-029 SHALL ignore redirect_valid and id_ready in IDLE.
REQ-030 SHALL latency: address presented to delivered instruction = ack cycle + 1.

Reset
REQ-031 SHALL on rst_n=0 immediately force state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc4=0, fetch_count=0.
REQ-032 SHALL abandon any outstanding request on reset mid-fetch; a late imem_ack after reset SHALL be ignored (IDLE).

Structure
REQ-033 SHALL take state encoding, RESET_PC default and WORD_BYTES=4 from shared package mips_pkg.
REQ-034 SHALL instantiate existing sub-module add4 for the pc increment; no other sub-modules.

Verification
REQ-035 SHALL test reset release, ack after 1 cycle, id_ready=1 -> addresses 0x0,0x4,0x8 fetched in order; fetch_count=3.
REQ-036 SHALL test id_ready=0 for 5 cycles in HOLD -> if_instr/if_pc4 unchanged, imem_req=0, fetch_count unchanged.
REQ-037 SHALL test redirect to 0x0000_0103 while request to 0x10 pending, ack 2 cycles later -> data dropped, next imem_addr=0x0000_0100.
REQ-038 SHALL test redirect coincident with ack at 0x20 -> if_valid stays 0, next imem_addr = redirect target.
REQ-039 SHALL test RESET_PC=32'hFFFF_FFFC -> if_pc4=0x0, second fetch address 0x0.
REQ-040 SHALL test rst_n low during FETCH, ack pulsed while low and the cycle after -> no if_valid, restart at RESET_PC.
